// File: rtl/mem_test_master_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_test_master_if
// Brief   : Avalon-MM bus bundle between the memory test master and a slave.
// Revision: 1.0  initial release
// ============================================================================
interface mem_test_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W+1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic              avm_read;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_read,
           avm_writedata,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_read,
           avm_writedata,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/mem_test_master.sv
`default_nettype none
// ============================================================================
// Module  : mem_test_master
// Brief   : Writes a selectable pattern to N words over Avalon-MM, reads them
//           back one at a time and counts mismatches.
// Revision: 1.0  initial release
// ============================================================================
module mem_test_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W:0]     num_words,
  input  logic [1:0]          pattern_sel,
  input  logic [31:0]         seed,
  mem_test_master_if.master   avm,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         error_count,
  output logic [ADDR_W-1:0]   first_fail_addr
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_READ_REQ  = 3'd2,
    S_READ_WAIT = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;     // one extra bit so N = DEPTH never wraps
  logic [ADDR_W:0]   n_q, n_d;
  logic [1:0]        sel_q, sel_d;
  logic [31:0]       seed_q, seed_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] ffa_q, ffa_d;

  logic [ADDR_W:0]   w_n_eff;
  logic              w_last;
  logic [31:0]       w_pattern;

  function automatic logic [31:0] pattern_f(input logic [1:0] sel,
                                            input logic [ADDR_W:0] i,
                                            input logic [31:0] sd);
    logic [31:0] r;
    case (sel)
      2'd0:    r = 32'(i);
      2'd1:    r = 32'h1 << i[4:0];
      2'd2:    r = i[0] ? 32'h5555AAAA : 32'hAAAA5555;
      default: r = sd;
    endcase
    return r;
  endfunction

  assign w_n_eff   = (num_words > DEPTH) ? DEPTH : num_words;
  assign w_last    = ((idx_q + 1'b1) == n_q);
  assign w_pattern = pattern_f(sel_q, idx_q, seed_q);

  // State and datapath registers; reset is asynchronous so outputs drop at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      sel_q   <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      ffa_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      sel_q   <= sel_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      ffa_q   <= ffa_d;
    end
  end

  // Next-state logic: write pass, then one-outstanding read/compare pass.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    sel_d   = sel_q;
    seed_d  = seed_q;
    err_d   = err_q;
    ffa_d   = ffa_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d   = '0;
          err_d   = '0;
          ffa_d   = '0;
          n_d     = w_n_eff;
          sel_d   = pattern_sel;
          seed_d  = seed;
          state_d = (w_n_eff == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (!avm.avm_waitrequest) begin
          if (w_last) begin
            idx_d   = '0;
            state_d = S_READ_REQ;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_READ_REQ: begin
        if (!avm.avm_waitrequest) begin
          state_d = S_READ_WAIT;
        end
      end
      S_READ_WAIT: begin
        if (avm.avm_readdatavalid) begin
          if (avm.avm_readdata != w_pattern) begin
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end
            if (err_q == 16'd0) begin
              ffa_d = idx_q[ADDR_W-1:0];
            end
          end
          if (w_last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_READ_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign avm.avm_write      = (state_q == S_WRITE);
  assign avm.avm_read       = (state_q == S_READ_REQ);
  assign avm.avm_chipselect = avm.avm_write | avm.avm_read;
  assign avm.avm_byteenable = 4'hF;
  assign avm.avm_address    = {idx_q[ADDR_W-1:0], 2'b00};
  assign avm.avm_writedata  = w_pattern;

  assign busy            = (state_q == S_WRITE) || (state_q == S_READ_REQ) ||
                           (state_q == S_READ_WAIT);
  assign done            = (state_q == S_DONE);
  assign pass            = done && (err_q == 16'd0);
  assign error_count     = err_q;
  assign first_fail_addr = ffa_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_test_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_test_master
// Brief   : Randomized self-checking bench with an Avalon-MM RAM slave model
//           and a word-level reference model of the expected test result.
// Revision: 1.0  initial release
// ============================================================================
module tb_mem_test_master;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_words = '0;
  logic [1:0]        pattern_sel = '0;
  logic [31:0]       seed = '0;
  logic              busy, done, pass;
  logic [15:0]       error_count;
  logic [ADDR_W-1:0] first_fail_addr;

  mem_test_master_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

  mem_test_master #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .pattern_sel(pattern_sel), .seed(seed), .avm(bus), .busy(busy),
    .done(done), .pass(pass), .error_count(error_count),
    .first_fail_addr(first_fail_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference pattern taken straight from the word-level definition.
  function automatic logic [31:0] ref_pattern(input int sel, input int i, input logic [31:0] sd);
    case (sel)
      0:       return 32'(i);
      1:       return 32'd1 << (i % 32);
      2:       return ((i % 2) == 0) ? 32'hAAAA5555 : 32'h5555AAAA;
      default: return sd;
    endcase
  endfunction

  // ---------------- slave model configuration (driven by the stimulus) ----
  int          cfg_wait = 0;
  int          cfg_maxlat = 1;
  bit          cfg_stray = 0;
  bit          bad_en [DEPTH];
  logic [31:0] bad_val [DEPTH];

  // ---------------- slave model state / logs (owned by the slave block) ---
  logic [31:0]       mem [DEPTH];
  int                wcnt = 0;
  logic              rdv_r = 1'b0;
  logic [31:0]       rdata_r = '0;
  bit                pend = 0;
  int                pcnt = 0;
  int                paddr = 0;
  bit                hold_v = 0;
  logic [ADDR_W+1:0] h_addr;
  logic              h_w, h_r;
  logic [31:0]       h_d;
  int                viol = 0;
  int                cmd_cycles = 0;
  logic [ADDR_W+1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [ADDR_W+1:0] rd_addr_q[$];

  assign bus.avm_waitrequest   = (bus.avm_read | bus.avm_write) && (wcnt < cfg_wait);
  assign bus.avm_readdatavalid = rdv_r;
  assign bus.avm_readdata      = rdata_r;

  function automatic logic [31:0] read_value(input int w);
    return bad_en[w] ? bad_val[w] : mem[w];
  endfunction

  always @(posedge clk) begin
    bit cmd;
    int lat;
    if (reset) begin
      rdv_r  <= 1'b0;
      pend   <= 0;
      wcnt   <= 0;
      hold_v <= 0;
    end else begin
      if (start && !busy) begin
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        viol = 0;
        cmd_cycles = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEADBEEF;
      end
      cmd = bus.avm_read | bus.avm_write;
      if (bus.avm_read && bus.avm_write) viol++;
      if (bus.avm_chipselect !== cmd) viol++;
      if (bus.avm_byteenable !== 4'hF) viol++;
      if (hold_v && (bus.avm_address !== h_addr || bus.avm_write !== h_w ||
                     bus.avm_read !== h_r || (h_w && bus.avm_writedata !== h_d)))
        viol++;
      hold_v <= cmd && bus.avm_waitrequest;
      h_addr <= bus.avm_address;
      h_w    <= bus.avm_write;
      h_r    <= bus.avm_read;
      h_d    <= bus.avm_writedata;
      if (cmd) cmd_cycles++;
      if (cmd) wcnt <= bus.avm_waitrequest ? wcnt + 1 : 0;

      rdv_r <= 1'b0;
      if (pend) begin
        if (pcnt == 1) begin
          rdv_r   <= 1'b1;
          rdata_r <= read_value(paddr);
          pend    <= 0;
        end else begin
          pcnt <= pcnt - 1;
        end
      end else if (cfg_stray && bus.avm_write && $urandom_range(0, 3) == 0) begin
        rdv_r   <= 1'b1;
        rdata_r <= $urandom;
      end

      if (bus.avm_write && !bus.avm_waitrequest) begin
        mem[int'(bus.avm_address[ADDR_W+1:2])] = bus.avm_writedata;
        wr_addr_q.push_back(bus.avm_address);
        wr_data_q.push_back(bus.avm_writedata);
      end
      if (bus.avm_read && !bus.avm_waitrequest) begin
        rd_addr_q.push_back(bus.avm_address);
        lat = $urandom_range(1, cfg_maxlat);
        if (lat == 1) begin
          rdv_r   <= 1'b1;
          rdata_r <= read_value(int'(bus.avm_address[ADDR_W+1:2]));
        end else begin
          pend  <= 1;
          pcnt  <= lat - 1;
          paddr <= int'(bus.avm_address[ADDR_W+1:2]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_bad();
    for (int i = 0; i < DEPTH; i++) begin
      bad_en[i]  = 0;
      bad_val[i] = '0;
    end
  endtask

  task automatic run(input int nw, input int sel, input logic [31:0] sd,
                     input int wt, input int maxlat, input bit inject,
                     output int cycles);
    int  n_eff;
    bit  injected;
    n_eff       = (nw > DEPTH) ? DEPTH : nw;
    cfg_wait    = wt;
    cfg_maxlat  = maxlat;
    cfg_stray   = 1;
    num_words   = (ADDR_W+1)'(nw);
    pattern_sel = 2'(sel);
    seed        = sd;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cycles   = 1;
    injected = 0;
    check("busy_after_start", busy, n_eff > 0);
    while (!done && cycles < 20 * n_eff + 50) begin
      if (inject && busy && !injected && $urandom_range(0, 7) == 0) begin
        start       = 1'b1;
        num_words   = (ADDR_W+1)'($urandom);
        pattern_sel = 2'($urandom);
        seed        = $urandom;
        injected    = 1;
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
      end
      cycles++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic verify(input string tag, input int nw, input int sel, input logic [31:0] sd);
    int          n;
    int          errs;
    int          first;
    logic [31:0] exp;
    logic [31:0] ret;
    n     = (nw > DEPTH) ? DEPTH : nw;
    errs  = 0;
    first = 0;
    check({tag, ".busy"}, busy, 0);
    check({tag, ".wr_cnt"}, wr_addr_q.size(), n);
    check({tag, ".rd_cnt"}, rd_addr_q.size(), n);
    for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
      check($sformatf("%s.wr_addr[%0d]", tag, k), wr_addr_q[k], 4 * k);
      check($sformatf("%s.wr_data[%0d]", tag, k), wr_data_q[k], ref_pattern(sel, k, sd));
    end
    for (int k = 0; k < n && k < rd_addr_q.size(); k++)
      check($sformatf("%s.rd_addr[%0d]", tag, k), rd_addr_q[k], 4 * k);
    for (int i = 0; i < n; i++) begin
      exp = ref_pattern(sel, i, sd);
      ret = bad_en[i] ? bad_val[i] : exp;
      if (ret !== exp) begin
        errs++;
        if (errs == 1) first = i;
      end
    end
    check({tag, ".error_count"}, error_count, (errs > 65535) ? 65535 : errs);
    check({tag, ".first_fail"}, first_fail_addr, first);
    check({tag, ".pass"}, pass, errs == 0);
    check({tag, ".protocol"}, viol, 0);
  endtask

  function automatic logic [63:0] idle_outs();
    return 64'({busy, done, pass, error_count, first_fail_addr,
                bus.avm_read, bus.avm_write, bus.avm_chipselect, bus.avm_address});
  endfunction

  initial begin
    int cyc;
    int nw, sel, wt, ml;
    logic [31:0] sd;
    bit found;

    clear_bad();
    repeat (3) @(negedge clk);
    check("reset_outputs", idle_outs(), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_action", idle_outs(), 0);

    // Pattern 0, 8 words, zero-wait, latency 1.
    run(8, 0, 32'h0, 0, 1, 0, cyc);
    check("p0_cycles", cyc, 25);
    verify("p0n8", 8, 0, 32'h0);

    // Checkerboard with word 2 forced to zero.
    bad_en[2] = 1; bad_val[2] = 32'h0;
    run(4, 2, 32'h0, 0, 1, 0, cyc);
    verify("p2bad", 4, 2, 32'h0);
    check("p2bad.ffa_const", first_fail_addr, 2);
    check("p2bad.err_const", error_count, 1);
    clear_bad();

    // Full depth, walking one, 2-cycle waitrequest on every command.
    run(DEPTH, 1, 32'h0, 2, 1, 1, cyc);
    verify("p1full", DEPTH, 1, 32'h0);
    check("p1full.last_addr", wr_addr_q.size() > 0 ? wr_addr_q[wr_addr_q.size()-1] : '0, 12'hFFC);
    check("p1full.last_data", wr_data_q.size() > 0 ? wr_data_q[wr_data_q.size()-1] : '0, 32'h8000_0000);

    // Zero-length run.
    run(0, 3, 32'h1234_5678, 0, 1, 0, cyc);
    check("n0_cycles", cyc, 1);
    check("n0_cmd_cycles", cmd_cycles, 0);
    verify("n0", 0, 3, 32'h1234_5678);

    // Over-range word count clamps to DEPTH.
    run(2000, 3, 32'hC0FF_EE11, 0, 1, 0, cyc);
    check("clamp_cycles", cyc, 1 + 3 * DEPTH);
    verify("clamp", 2000, 3, 32'hC0FF_EE11);

    // Randomized runs with corrupted words, waits, latencies, ignored starts.
    for (int r = 0; r < 12; r++) begin
      nw  = $urandom_range(0, 48);
      sel = $urandom_range(0, 3);
      sd  = $urandom;
      wt  = $urandom_range(0, 2);
      ml  = $urandom_range(1, 3);
      clear_bad();
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 1) == 1) begin
          int w;
          w = $urandom_range(0, 47);
          bad_en[w]  = 1;
          bad_val[w] = ($urandom_range(0, 1) == 1) ? 32'h0 : $urandom;
        end
      end
      run(nw, sel, sd, wt, ml, 1, cyc);
      if (wt == 0 && ml == 1) check($sformatf("rnd%0d.cycles", r), cyc, 1 + 3 * nw);
      verify($sformatf("rnd%0d", r), nw, sel, sd);
    end

    // Reset asserted while waiting for read data, after an error was counted.
    clear_bad();
    bad_en[0] = 1; bad_val[0] = 32'h0BAD_0BAD;
    cfg_wait = 0; cfg_maxlat = 3; cfg_stray = 0;
    num_words = 11'd16; pattern_sel = 2'd3; seed = 32'h5A5A_1234;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (busy && !bus.avm_read && !bus.avm_write && error_count != 0) found = 1;
      else @(negedge clk);
    end
    check("rst_reached_read_wait", found, 1);
    #1 reset = 1'b1;
    #1 check("rst_async_outputs", idle_outs(), 0);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_then_idle", idle_outs(), 0);
    clear_bad();
    run(16, 3, 32'h5A5A_1234, 0, 1, 0, cyc);
    check("post_rst_cycles", cyc, 1 + 3 * 16);
    verify("post_rst", 16, 3, 32'h5A5A_1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_test_master.md
MEM_TEST_MASTER -- requirements
Module: mem_test_master

Interface
- Parameters (name, default, meaning):
  - REQ-001 The block SHALL have parameter ADDR_W, default 10: word-address width; DEPTH = 2**ADDR_W words.
  - REQ-002 The block SHALL have parameter DATA_W, default 32: data width; fixed at 32 for byteenable width 4.
- Ports (name  direction  width  meaning):
  - REQ-003 clk  in  1  single clock; all state changes on rising edge.
  - REQ-004 reset  in  1  asynchronous, active-high reset.
  - REQ-005 start  in  1  one-cycle request to begin a test run.
  - REQ-006 num_words  in  ADDR_W+1  word count, sampled at accepted start.
  - REQ-007 pattern_sel  in  2  pattern: 0 addr-as-data, 1 walking-one, 2 checkerboard, 3 seed.
  - REQ-008 seed  in  32  constant for pattern 3, sampled at accepted start.
  - REQ-009 avm_address  out  ADDR_W+2  byte address = word index * 4.
  - REQ-010 avm_byteenable  out  4  constant 4'hF.
  - REQ-011 avm_chipselect  out  1  high whenever avm_read or avm_write is high.
  - REQ-012 avm_write / avm_read  out  1 each  Avalon-MM commands, never both high.
  - REQ-013 avm_writedata  out  32  pattern word.
  - REQ-014 avm_readdata  in  32  read return data.
  - REQ-015 avm_waitrequest  in  1  slave stall; command held while high.
  - REQ-016 avm_readdatavalid  in  1  qualifies avm_readdata.
  - REQ-017 busy  out  1  high from accepted start until DONE is entered.
  - REQ-018 done  out  1  level; high in DONE until next accepted start.
  - REQ-019 pass  out  1  valid when done: 1 iff error_count == 0.
  - REQ-020 error_count  out  16  mismatch count, saturating at 16'hFFFF.
  - REQ-021 first_fail_addr  out  ADDR_W  word index of first mismatch; 0 if none.

Function
- REQ-022 The FSM SHALL have states IDLE, WRITE, READ_REQ, READ_WAIT, DONE.
- REQ-023 Start acceptance and initialization:
  - start is accepted only in IDLE or DONE; start in any other state is ignored.
  - Accepting start clears done, error_count and first_fail_addr; sets index to 0; latches num_words, pattern_sel and seed.
  - Effective count N = min(num_words, DEPTH).
- REQ-024 If N == 0, the FSM SHALL go directly to DONE one cycle after start, with pass = 1 and no bus cycles.
- REQ-025 WRITE state:
  - Drive avm_write with avm_address = index*4 and pattern(index).
  - Hold all command signals while avm_waitrequest = 1.
  - On a cycle with waitrequest = 0, increment index; after write N-1 completes, go to READ_REQ with index = 0.
- REQ-026 Pattern definition for word index i:
  - 0: zero-extended i.
  - 1: 32'h1 << i[4:0].
  - 2: 32'hAAAA5555 if i is even, 32'h5555AAAA if i is odd.
  - 3: latched seed.
- REQ-027 Read sequence, one outstanding read at most:
  - READ_REQ drives avm_read at index*4 until waitrequest = 0, then goes to READ_WAIT.
  - READ_WAIT waits for avm_readdatavalid, which may arrive 1 or more cycles later.
- REQ-028 Compare in READ_WAIT:
  - On readdatavalid, compare avm_readdata with pattern(index).
  - On mismatch, increment error_count, saturating; if it was 0, capture first_fail_addr = index.
  - If index == N-1, go to DONE; otherwise increment index and return to READ_REQ.
- REQ-029 readdatavalid received outside READ_WAIT SHALL be ignored.
- REQ-030 Index width SHALL be ADDR_W+1 so that N = DEPTH terminates without wrap-around; avm_address uses index[ADDR_W-1:0].
- REQ-031 Total runtime with zero-wait slave and 1-cycle read latency SHALL be 1 + N + 2N cycles from start to done.

Reset
- REQ-032 Asserting reset SHALL, at any time including mid-run, force IDLE and set:
  - all avm_* command outputs and busy, done, pass to 0;
  - error_count, first_fail_addr, index and avm_address to 0.
- REQ-033 After reset deasserts, the block SHALL take no action until a start pulse.

Verification
- REQ-034 Pattern 0, N = 8, zero-wait RAM model with 1-cycle read latency -> 8 writes of data 0..7 at addresses 0x00..0x1C, 8 reads; done in cycle 25; pass = 1, error_count = 0.
- REQ-035 Pattern 2, N = 4, model forcing word 2 to 32'h0 -> error_count = 1, first_fail_addr = 2, pass = 0.
- REQ-036 Pattern 1, N = 1024, waitrequest high 2 cycles on every command -> last write at address 0x0FFC with data 32'h8000_0000; no index wrap; pass = 1.
- REQ-037 N = 0 -> done one cycle after start, no avm_write/avm_read pulses, pass = 1; start during busy ignored (index and counters unaffected).
- REQ-038 reset asserted during READ_WAIT -> outputs 0 in the same cycle asynchronously; new start afterwards runs cleanly with error_count starting at 0.
